seq_booth_mul: RTL and testbench
================================

Name: seq_booth_mul

Overview:
Sequential signed multiplier for the ALU. It is the inverse operation of the iterative restoring divider, and uses the same start/ready handshake so the control unit drives both identically. Radix-2 Booth recoding, one step per clock. The 2*WIDTH product is presented as hi/lo halves that feed the HI/LO registers.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, rising-edge.
clr_n  input  1  reset; one clock, asynchronous assert, active-low.
start  input  1  request; accepted only when ready=1.
multiplicand  input  WIDTH  signed operand M; sampled on the accepting edge only.
multiplier  input  WIDTH  signed operand Q; sampled on the accepting edge only.
hi  output  WIDTH  upper half of the signed product.
lo  output  WIDTH  lower half of the signed product.
ready  output  1  idle and able to accept start.
done  output  1  one-cycle pulse when hi/lo become valid.

Behaviour:
- Reset (clr_n=0, async):
  - state=IDLE; A, Q, q_m1 and count cleared.
  - hi=0, lo=0, ready=1, done=0.
- Datapath registers:
  - A: WIDTH+1 bits, sign-extended, so subtracting M=-2^(WIDTH-1) cannot overflow.
  - Q: WIDTH bits. q_m1: 1 bit. Mreg: WIDTH+1 bits, sign-extended. count: clog2(WIDTH)+1 bits.
- IDLE:
  - ready=1.
  - On an edge with start=1: A=0, Q=multiplier, q_m1=0, Mreg=sext(multiplicand), count=WIDTH, go to BUSY.
  - hi/lo keep their previous result until the following completion.
- BUSY (ready=0), each edge:
  - Recode {Q[0],q_m1}: 01 -> A=A+Mreg; 10 -> A=A-Mreg; 00/11 -> no add.
  - Arithmetic shift right of {A,Q,q_m1} by 1; A's MSB is replicated.
  - count=count-1.
  - The step in which count goes 1->0 also loads hi=A[WIDTH-1:0] and lo=Q (post-shift values), pulses done=1 for exactly one cycle, and returns to IDLE.
- Latency:
  - Accepting edge is cycle 0; done and ready are high after edge WIDTH.
  - A new start can be accepted on the edge right after done, so back-to-back throughput is one result per WIDTH+1 cycles.
- start while BUSY is ignored; operands are not re-sampled and the result is unaffected.
- Holding start high continuously restarts the multiplier on every IDLE cycle using the current operands.
- Reset mid-operation aborts immediately. No done pulse; hi/lo read 0.
- Operand changes after acceptance have no effect.
- The result is the exact two's-complement product; no overflow flag is produced.
- Zero operands take the full WIDTH cycles; there is no early exit.

Optional Feature:
MUL_RADIX4_EN
- Defined:
  - Radix-4 Booth: recode {Q[1],Q[0],q_m1} into 0, ±M or ±2M, then shift by 2 per cycle.
  - count starts at WIDTH/2; done arrives after edge WIDTH/2.
  - A widens to WIDTH+2 bits.
  - WIDTH must be even; elaboration error otherwise.
- Undefined: radix-2 behaviour as described above.
- Handshake, reset and result values are identical in both builds; only latency differs.

Decomposition:
- Package mul_pkg holds:
  - default WIDTH constant;
  - state type {IDLE, BUSY};
  - Booth recode constants (OP_NONE, OP_ADD, OP_SUB, OP_ADD2, OP_SUB2).
- Sub-module booth_step: purely combinational.
  - Inputs: A, Q, q_m1, Mreg. Outputs: next A, Q, q_m1.
  - Radix selected by the macro.
- Top level holds only registers, counter and FSM.

Test Plan:
- Reset, then start with 100 x 3 -> ready low for 32 cycles; done one pulse; hi=0x00000000, lo=0x0000012C.
- -7 x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; and 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- Start 5 x 5; at cycle 10 drive start=1 with 9 x 9 and change operands -> result 25; exactly one done; second request not accepted until ready.
- Start 12345 x -2; pull clr_n low at cycle 15 -> ready=1, hi=lo=0, no done; then 2 x 3 -> lo=6.
- With MUL_RADIX4_EN: repeat the first three scenarios -> identical results; done after 16 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and Booth recoding helpers for the sequential signed multiplier.
// Recoding for both radix-2 and radix-4 (MUL_RADIX4_EN) lives here.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_ADD2,
        OP_SUB2
    } booth_op_t;

    // Radix-2: {Q[0], q_m1}
    function automatic booth_op_t recode_r2(input logic [1:0] bits);
        booth_op_t op;
        case (bits)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

    // Radix-4: {Q[1], Q[0], q_m1}
    function automatic booth_op_t recode_r4(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = OP_ADD;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB;
            default:        op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: recode, add/subtract, arithmetic shift.
// Radix-4 (two bits per step) when MUL_RADIX4_EN is defined, radix-2 otherwise.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = WIDTH + 1
) (
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [AW-1:0]    a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [AW-1:0] m_ext;
    logic [AW-1:0] sum;
    booth_op_t     op;

    assign m_ext = AW'($signed(m));

`ifdef MUL_RADIX4_EN
    assign op = recode_r4({q[1:0], q_m1});
`else
    assign op = recode_r2({q[0], q_m1});
`endif

    always_comb begin
        sum = a;
        case (op)
            OP_ADD:  sum = a + m_ext;
            OP_SUB:  sum = a - m_ext;
            OP_ADD2: sum = a + (m_ext << 1);
            OP_SUB2: sum = a - (m_ext << 1);
            default: sum = a;
        endcase
    end

`ifdef MUL_RADIX4_EN
    assign a_next    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_next    = {sum[1:0], q[WIDTH-1:2]};
    assign q_m1_next = q[1];
`else
    assign a_next    = {sum[AW-1], sum[AW-1:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];
`endif

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential signed Booth multiplier with start/ready handshake and done pulse.
// Define MUL_RADIX4_EN for radix-4 stepping (WIDTH/2 cycles, WIDTH must be even).
module seq_booth_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ready,
    output logic             done
);

`ifdef MUL_RADIX4_EN
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = WIDTH / 2;
    if (WIDTH % 2 != 0) begin : g_width_check
        $error("seq_booth_mul: WIDTH must be even for radix-4");
    end
`else
    localparam int AW    = WIDTH + 1;
    localparam int STEPS = WIDTH;
`endif

    localparam int            CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(STEPS);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             finish;

    logic [AW-1:0]    a;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH:0]   mreg;
    logic [CW-1:0]    count;

    logic [AW-1:0]    a_next;
    logic [WIDTH-1:0] q_next;
    logic             q_m1_next;

    booth_step #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_step (
        .a         (a),
        .q         (q),
        .q_m1      (q_m1),
        .m         (mreg),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is only honoured in IDLE; BUSY ignores it entirely.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            mreg  <= '0;
            count <= '0;
        end else if (accept) begin
            a     <= '0;
            q     <= multiplier;
            q_m1  <= 1'b0;
            mreg  <= {multiplicand[WIDTH-1], multiplicand};
            count <= COUNT_INIT;
        end else if (state == BUSY) begin
            a     <= a_next;
            q     <= q_next;
            q_m1  <= q_m1_next;
            count <= count - CW'(1);
        end
    end

    // hi/lo hold the last completed product until the next completion.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                hi <= a_next[WIDTH-1:0];
                lo <= q_next;
            end
        end
    end

    assign ready = (state == IDLE);

endmodule

// File: tb/tb_seq_booth_mul.sv
// Directed-vector bench for seq_booth_mul: driver pushes expected products,
// a negedge monitor pops and compares them whenever done pulses.
module tb_seq_booth_mul;

`ifdef MUL_RADIX4_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ready;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_done = 0;

    logic [63:0] exp_q[$];
    int          acc_q[$];

    seq_booth_mul #(.WIDTH(32)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .ready        (ready),
        .done         (done)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (clr_n && done) begin
            logic [63:0] e;
            int          a;
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("product", {hi, lo}, e);
                check("latency", 64'(cyc - a), 64'(LAT));
            end
        end
    end

    // driver tasks; all are entered and left on a falling edge
    task automatic wait_idle(output int n);
        n = 0;
        while (!ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready=%0b after %0d cycles expected 1", ready, n);
        end
    endtask

    task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_mul(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
        int n;
        issue(m, q, exp);
        @(negedge clk);
        wait_idle(n);
        check("busy_cycles", 64'(n), 64'(LAT));
    endtask

    initial begin
        int          n;
        int          done_before;

        clr_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        clr_n = 1'b1;
        @(negedge clk);

        // back-to-back directed vectors
        do_mul(32'd100,       32'd3,         64'h00000000_0000012C);
        do_mul(32'hFFFFFFF9,  32'd6,         64'hFFFFFFFF_FFFFFFD6);
        do_mul(32'h80000000,  32'h80000000,  64'h40000000_00000000);
        do_mul(32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001);
        do_mul(32'hFFFFFFFF,  32'hFFFFFFFF,  64'h00000000_00000001);
        do_mul(32'd0,         32'h12345678,  64'h00000000_00000000);
        do_mul(32'h80000000,  32'h7FFFFFFF,  64'hC0000000_80000000);

        // start held while busy with new operands: first result unaffected
        issue(32'd5, 32'd5, 64'd25);
        repeat (10) @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        wait_idle(n);
        exp_q.push_back(64'd81);
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_idle(n);
        check("busy_cycles_restart", 64'(n), 64'(LAT));
        repeat (5) @(negedge clk);
        check("hold_hilo", {hi, lo}, 64'd81);

        // abort mid-operation
        issue(32'd12345, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFF9F8E);
        repeat (15) @(negedge clk);
        done_before = n_done;
        clr_n = 1'b0;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        clr_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done - done_before), 64'd0);
        do_mul(32'd2, 32'd3, 64'd6);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
